// File: rtl/finger_dancer_pkg.sv
// Shared types and constants for the finger-dancer note pattern generator and judge.
package finger_dancer_pkg;
    localparam int PAT_W   = 4;
    localparam int SCORE_W = 16;
    localparam int COMBO_W = 8;
    localparam int WIN_W   = 16;

    localparam logic [PAT_W-1:0] PAT_STEP   = 4'd3;
    localparam logic [PAT_W-1:0] PAT_SEED   = 4'b0001;
    localparam logic [WIN_W-1:0] PAT_WINDOW = 16'd50000;

    typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_JUDGED} judge_state_e;

    typedef struct packed {
        logic hit;
        logic miss;
    } verdict_t;

    localparam verdict_t V_NONE = '{hit: 1'b0, miss: 1'b0};
    localparam verdict_t V_HIT  = '{hit: 1'b1, miss: 1'b0};
    localparam verdict_t V_MISS = '{hit: 1'b0, miss: 1'b1};
endpackage

// File: rtl/pattern_judge_if.sv
// Player-side bus: song control and debounced keys in, note/judgement/score out.
interface pattern_judge_if #(
    parameter int SCORE_W = finger_dancer_pkg::SCORE_W
);
    import finger_dancer_pkg::*;

    logic               start;
    logic               stop;
    logic               beat;
    logic [PAT_W-1:0]   keys;
    logic [PAT_W-1:0]   expected;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic               busy;

    modport master (output start, stop, beat, keys,
                    input  expected, hit, miss, score, combo, busy);
    modport slave  (input  start, stop, beat, keys,
                    output expected, hit, miss, score, combo, busy);
endinterface

// File: rtl/pattern_step.sv
// Note step function shared with the generator so both ends walk the same sequence.
module pattern_step
    import finger_dancer_pkg::*;
(
    input  logic [PAT_W-1:0] i_cur,
    output logic [PAT_W-1:0] o_next
);
    // Natural 4-bit wrap gives the mod-16 behaviour.
    assign o_next = i_cur + PAT_STEP;
endmodule

// File: rtl/pattern_judge.sv
// Judges debounced key presses against the current note within a timing window,
// and keeps score and combo.
module pattern_judge
    import finger_dancer_pkg::*;
#(
    parameter logic [WIN_W-1:0] WINDOW     = PAT_WINDOW,
    parameter int               SCORE_BITS = SCORE_W
)(
    input  logic           clk,
    input  logic           rst_n,
    pattern_judge_if.slave bus
);
    judge_state_e r_state, w_state_nxt;

    logic [PAT_W-1:0]      r_keys_q, r_exp, w_exp_step, w_cur;
    logic [WIN_W-1:0]      r_cnt;
    logic [SCORE_BITS-1:0] r_score;
    logic [COMBO_W-1:0]    r_combo;
    verdict_t              r_out, r_pend, w_close, w_judge, w_emit, w_pend_nxt;
    logic                  w_active, w_press, w_judge_press, w_expire;

    pattern_step u_step (.i_cur(r_exp), .o_next(w_exp_step));

    assign w_active = (r_state != ST_IDLE);
    assign w_press  = (bus.keys != '0) && (r_keys_q == '0);
    // A press coinciding with a beat belongs to the new note.
    assign w_cur    = bus.beat ? w_exp_step : r_exp;

    always_comb begin
        w_state_nxt   = r_state;
        w_close       = V_NONE;
        w_judge       = V_NONE;
        w_emit        = V_NONE;
        w_pend_nxt    = V_NONE;
        w_judge_press = w_active && w_press && (bus.beat || r_state == ST_OPEN);
        w_expire      = (r_state == ST_OPEN) && !bus.beat && !w_press && (r_cnt <= WIN_W'(1));

        if (w_active && bus.beat && r_state == ST_OPEN)
            w_close = (r_exp == '0) ? V_HIT : V_MISS;

        if (w_judge_press)
            w_judge = (bus.keys == w_cur) ? V_HIT : V_MISS;
        else if (w_expire)
            w_judge = (r_exp == '0) ? V_HIT : V_MISS;

        // Old note's verdict goes out first; the new note's waits one cycle.
        if (w_close != V_NONE) begin
            w_emit     = w_close;
            w_pend_nxt = w_judge;
        end else if (r_pend != V_NONE) begin
            w_emit = r_pend;
        end else begin
            w_emit = w_judge;
        end

        if (bus.start)
            w_state_nxt = ST_OPEN;
        else if (bus.stop)
            w_state_nxt = ST_IDLE;
        else if (w_active) begin
            if (w_judge != V_NONE)
                w_state_nxt = ST_JUDGED;
            else if (bus.beat)
                w_state_nxt = ST_OPEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keys_q <= '0;
            r_exp    <= PAT_SEED;
            r_cnt    <= '0;
            r_score  <= '0;
            r_combo  <= '0;
            r_out    <= V_NONE;
            r_pend   <= V_NONE;
        end else begin
            r_keys_q <= bus.keys;
            if (bus.start) begin
                r_exp   <= PAT_SEED;
                r_cnt   <= WINDOW;
                r_score <= '0;
                r_combo <= '0;
                r_out   <= V_NONE;
                r_pend  <= V_NONE;
            end else if (bus.stop || !w_active) begin
                r_out  <= V_NONE;
                r_pend <= V_NONE;
            end else begin
                r_out  <= w_emit;
                r_pend <= w_pend_nxt;
                if (bus.beat) begin
                    r_exp <= w_exp_step;
                    r_cnt <= WINDOW;
                end else if (r_state == ST_OPEN && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (w_emit.hit) begin
                    if (r_score != '1) r_score <= r_score + 1'b1;
                    if (r_combo != '1) r_combo <= r_combo + 1'b1;
                end else if (w_emit.miss) begin
                    r_combo <= '0;
                end
            end
        end
    end

    assign bus.expected = r_exp;
    assign bus.hit      = r_out.hit;
    assign bus.miss     = r_out.miss;
    assign bus.score    = r_score;
    assign bus.combo    = r_combo;
    assign bus.busy     = w_active;
endmodule
